mdu_ctrl: RTL and testbench

//  Sequences the multiply/divide unit that feeds the HI_LO writeback source. Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO

---
 rtl/mdu_ctrl_pkg.sv | 23 ++
 rtl/mdu_arith.sv | 60 ++++++
 rtl/mdu_ctrl.sv | 120 ++++++++++++
 tb/tb_mdu_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and FSM states.
package mdu_ctrl_pkg;

    // MDU op encodings as driven on e_op by the execute stage
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // True for the multi-cycle ops (MULT/MULTU/DIV/DIVU)
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit multiply and 32-bit divide with div-by-zero and
// signed-overflow flags. Result is {hi, lo}; zero for non-arithmetic ops.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o,
    output logic        div_ovf_o
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] rt_safe;
    logic        [31:0] q_s;
    logic        [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;

    assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

    assign div_zero_o = (rt_i == 32'd0);
    assign div_ovf_o  = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);

    // Divisor of 1 for the zero and overflow cases keeps the divider well defined;
    // x/1 also happens to give the architected overflow answer (q=x, r=0).
    assign rt_safe = (div_zero_o || div_ovf_o) ? 32'd1 : rt_i;

    assign q_s = $signed(rs_i) / $signed(rt_safe);
    assign r_s = $signed(rs_i) % $signed(rt_safe);
    assign q_u = rs_i / rt_safe;
    assign r_u = rs_i % rt_safe;

    // Select the result pair for the requested op
    always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        case (op_i)
            MD_MULT:  {hi_o, lo_o} = prod_s;
            MD_MULTU: {hi_o, lo_o} = prod_u;
            MD_DIV: begin
                hi_o = r_s;
                lo_o = q_s;
            end
            MD_DIVU: begin
                hi_o = r_u;
                lo_o = q_u;
            end
            default: begin
                hi_o = 32'd0;
                lo_o = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models op latency with a down-counter
// and requests a decode stall while a HI/LO-class instruction would see a stale result.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e_start_i,
    input  logic [2:0]  e_op_i,
    input  logic [31:0] e_rs_i,
    input  logic [31:0] e_rt_i,
    input  logic        e_cancel_i,
    input  logic        d_is_md_i,
    output logic        busy_o,
    output logic        stall_req_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);

    mdu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        tmp_hi_q;
    logic [31:0]        tmp_lo_q;
    logic               tmp_wr_q;

    logic               accept;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               div_zero;
    logic               div_ovf;

    assign accept = e_start_i & ~e_cancel_i;

    mdu_arith u_arith (
        .op_i       (e_op_i),
        .rs_i       (e_rs_i),
        .rt_i       (e_rt_i),
        .hi_o       (res_hi),
        .lo_o       (res_lo),
        .div_zero_o (div_zero),
        .div_ovf_o  (div_ovf)
    );

    // FSM, latency counter, result temps and HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            tmp_wr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (e_op_i)
                            MD_MULT, MD_MULTU: begin
                                state_q  <= ST_MUL;
                                cnt_q    <= MULT_INIT;
                                busy_q   <= 1'b1;
                                tmp_hi_q <= res_hi;
                                tmp_lo_q <= res_lo;
                                tmp_wr_q <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                state_q  <= ST_DIV;
                                cnt_q    <= DIV_INIT;
                                busy_q   <= 1'b1;
                                // Pin the signed overflow answer rather than trusting the divider
                                tmp_hi_q <= div_ovf ? 32'd0 : res_hi;
                                tmp_lo_q <= div_ovf ? 32'h8000_0000 : res_lo;
                                // Divide by zero still occupies the unit but leaves HI/LO alone
                                tmp_wr_q <= ~div_zero;
                            end
                            MD_MTHI: hi_q <= e_rs_i;
                            MD_MTLO: lo_q <= e_rs_i;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    // New accepts are dropped here; the stall keeps a sane pipeline from issuing them
                    if (cnt_q == '0) begin
                        if (tmp_wr_q) begin
                            hi_q <= tmp_hi_q;
                            lo_q <= tmp_lo_q;
                        end
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign stall_req_o = d_is_md_i & ((accept & is_muldiv(e_op_i)) | busy_q);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed cases followed by random traffic
// against a reference model of HI/LO and unit occupancy.
module tb_mdu_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        rst_n;
    logic        e_start;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_cancel;
    logic        d_is_md;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .e_start_i   (e_start),
        .e_op_i      (e_op),
        .e_rs_i      (e_rs),
        .e_rt_i      (e_rt),
        .e_cancel_i  (e_cancel),
        .d_is_md_i   (d_is_md),
        .busy_o      (busy),
        .stall_req_o (stall_req),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state: architected HI/LO plus remaining busy cycles
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_left = 0;
    logic [31:0] m_pend_hi;
    logic [31:0] m_pend_lo;
    logic        m_pend_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the unit should compute, from plain arithmetic
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            exp_q.delete();
        end else if (m_left != 0) begin
            m_left--;
            if (m_left == 0 && m_pend_wr) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end
        end else if (e_start && !e_cancel) begin
            exp_t        e;
            longint      sa, sb;
            int          da, db;
            case (e_op)
                3'd0: begin
                    sa = longint'($signed(e_rs));
                    sb = longint'($signed(e_rt));
                    {m_pend_hi, m_pend_lo} = sa * sb;
                    m_pend_wr = 1'b1;
                    m_left = MULT_LAT;
                end
                3'd1: begin
                    {m_pend_hi, m_pend_lo} = longint'({32'd0, e_rs}) * longint'({32'd0, e_rt});
                    m_pend_wr = 1'b1;
                    m_left = MULT_LAT;
                end
                3'd2: begin
                    m_left = DIV_LAT;
                    m_pend_wr = (e_rt != 0);
                    if (e_rs == 32'h8000_0000 && e_rt == 32'hFFFF_FFFF) begin
                        m_pend_lo = 32'h8000_0000;
                        m_pend_hi = 32'd0;
                    end else if (e_rt != 0) begin
                        da = int'(e_rs);
                        db = int'(e_rt);
                        m_pend_lo = 32'(da / db);
                        m_pend_hi = 32'(da % db);
                    end
                end
                3'd3: begin
                    m_left = DIV_LAT;
                    m_pend_wr = (e_rt != 0);
                    if (e_rt != 0) begin
                        m_pend_lo = e_rs / e_rt;
                        m_pend_hi = e_rs % e_rt;
                    end
                end
                3'd4: m_hi = e_rs;
                3'd5: m_lo = e_rs;
                default: ;
            endcase
            if (e_op <= 3'd3) begin
                e.hi  = m_pend_wr ? m_pend_hi : m_hi;
                e.lo  = m_pend_wr ? m_pend_lo : m_lo;
                e.lat = m_left;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: per-cycle output checks, and scoreboard pop whenever an op retires
    logic prev_busy = 1'b0;
    int   blen = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_busy", {63'd0, busy}, 64'd0);
            check("reset_hi", {32'd0, hi}, 64'd0);
            check("reset_lo", {32'd0, lo}, 64'd0);
            prev_busy = 1'b0;
            blen = 0;
        end else begin
            logic exp_stall;
            exp_stall = d_is_md && ((e_start && !e_cancel && e_op <= 3'd3) || (m_left != 0));
            check("stall_req", {63'd0, stall_req}, {63'd0, exp_stall});
            check("busy", {63'd0, busy}, {63'd0, (m_left != 0)});
            check("hi", {32'd0, hi}, {32'd0, m_hi});
            check("lo", {32'd0, lo}, {32'd0, m_lo});
            if (busy) blen++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL retire_unexpected: got retire expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("retire_hi", {32'd0, hi}, {32'd0, e.hi});
                    check("retire_lo", {32'd0, lo}, {32'd0, e.lo});
                    check("retire_len", 64'(blen), 64'(e.lat));
                    $display("retire lat=%0d hi=%h lo=%h", blen, hi, lo);
                end
                blen = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic cyc(input logic st, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic cn, input logic md);
        e_start  = st;
        e_op     = op;
        e_rs     = rs;
        e_rt     = rt;
        e_cancel = cn;
        d_is_md  = md;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic md);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, md);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n    = 1'b0;
        e_start  = 1'b0;
        e_op     = 3'd0;
        e_rs     = 32'd0;
        e_rt     = 32'd0;
        e_cancel = 1'b0;
        d_is_md  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1, 1'b0);

        // MULT -2*3
        cyc(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        idle(7, 1'b0);
        // MULTU with decode holding a HI/LO instruction
        cyc(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        idle(6, 1'b1);
        idle(1, 1'b0);
        // DIV -7/2, then DIVU by zero
        cyc(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(11, 1'b0);
        cyc(1'b1, 3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        idle(11, 1'b0);
        // signed overflow
        cyc(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(11, 1'b0);
        // cancelled start
        cyc(1'b1, 3'd0, 32'd5, 32'd6, 1'b1, 1'b1);
        idle(2, 1'b0);
        // MTHI in idle, MTLO while busy
        cyc(1'b1, 3'd4, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        idle(1, 1'b0);
        cyc(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 1'b0);
        cyc(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        idle(7, 1'b0);
        // reset in the middle of a DIV
        cyc(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(3, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(15, 1'b0);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        idle(15, 1'b0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
